// File: rtl/dual_priority_sched.sv
// ---------------------------------------------------------------------------
// dual_priority_sched
//
// Sticky request collector with a dual priority encoder. Incoming request
// bits are OR-ed into a 12-bit pending register. The highest and the
// second-highest pending indices are presented as registered 4-bit codes.
// Each code has its own valid/ready handshake. A granted index is retired
// from the pending set on the edge where its handshake completes.
//
// Handshake semantics (identical for the first_* and second_* ports):
//   - A transfer happens on a rising clk edge where valid=1 and ready=1.
//   - Valid never depends on ready.
//   - The code may change while valid stays high and no transfer has
//     happened, for example when a higher-priority request arrives.
//     Consumers sample the code only on the transfer edge.
//   - The two handshakes are independent. Neither, either or both may
//     complete in the same cycle.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   req           in   N_REQ  request bits, OR-ed into pending
//   first_code    out  CODE_W highest pending index (0 when first_valid=0)
//   first_valid   out  first_code holds a pending request
//   first_ready   in   consumer of first_code accepts this cycle
//   second_code   out  CODE_W second-highest pending index (0 when invalid)
//   second_valid  out  second_code holds a request distinct from first_code
//   second_ready  in   consumer of second_code accepts this cycle
//   pending       out  N_REQ  current pending register
//
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module dual_priority_sched #(
  parameter int N_REQ  = 12,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] first_code,
  output logic              first_valid,
  input  logic              first_ready,
  output logic [CODE_W-1:0] second_code,
  output logic              second_valid,
  input  logic              second_ready,
  output logic [N_REQ-1:0]  pending
);

  logic [N_REQ-1:0]  pending_q,      pending_d;
  logic [CODE_W-1:0] first_code_q,   first_code_d;
  logic              first_valid_q,  first_valid_d;
  logic [CODE_W-1:0] second_code_q,  second_code_d;
  logic              second_valid_q, second_valid_d;

  logic              first_grant;
  logic              second_grant;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  masked;

  // Grants are judged against the registered outputs the consumers saw.
  assign first_grant  = first_valid_q  & first_ready;
  assign second_grant = second_valid_q & second_ready;

  // Retire granted indices. A req bit on an index being granted in the same
  // cycle is ORed back in afterwards, so it survives as a fresh request.
  always_comb begin
    clr = '0;
    if (first_grant) begin
      clr[first_code_q] = 1'b1;
    end
    if (second_grant) begin
      clr[second_code_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | req;
  end

  // First encoder: scanning upward and letting later hits overwrite earlier
  // ones leaves the highest set index.
  always_comb begin
    first_valid_d = 1'b0;
    first_code_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_d[i]) begin
        first_valid_d = 1'b1;
        first_code_d  = CODE_W'(i);
      end
    end
  end

  // Second encoder: same scan with the winning bit removed, which makes
  // second_code < first_code whenever both are valid.
  always_comb begin
    masked = pending_d;
    if (first_valid_d) begin
      masked[first_code_d] = 1'b0;
    end
    second_valid_d = 1'b0;
    second_code_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (masked[i]) begin
        second_valid_d = 1'b1;
        second_code_d  = CODE_W'(i);
      end
    end
  end

  // Reset wins over everything, including grants completing in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= '0;
      first_code_q   <= '0;
      first_valid_q  <= 1'b0;
      second_code_q  <= '0;
      second_valid_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      first_code_q   <= first_code_d;
      first_valid_q  <= first_valid_d;
      second_code_q  <= second_code_d;
      second_valid_q <= second_valid_d;
    end
  end

  assign pending      = pending_q;
  assign first_code   = first_code_q;
  assign first_valid  = first_valid_q;
  assign second_code  = second_code_q;
  assign second_valid = second_valid_q;

endmodule

// File: tb/tb_dual_priority_sched.sv
// ---------------------------------------------------------------------------
// tb_dual_priority_sched
//
// Directed bench for dual_priority_sched. A table of per-cycle records
// {inputs, expected outputs} is applied one record per clock. A drain
// sequence then checks the order of grant pairs against an expected queue.
// Inputs change on the falling edge. Outputs are checked 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_dual_priority_sched;

  logic        clk;
  logic        reset;
  logic [11:0] req;
  logic [3:0]  first_code;
  logic        first_valid;
  logic        first_ready;
  logic [3:0]  second_code;
  logic        second_valid;
  logic        second_ready;
  logic [11:0] pending;

  int n_compared   = 0;
  int n_mismatched = 0;

  dual_priority_sched #(.N_REQ(12), .CODE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .first_code   (first_code),
    .first_valid  (first_valid),
    .first_ready  (first_ready),
    .second_code  (second_code),
    .second_valid (second_valid),
    .second_ready (second_ready),
    .pending      (pending)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [11:0] req;
    logic        fr;
    logic        sr;
    logic [11:0] pend;
    logic        fv;
    logic [3:0]  fc;
    logic        sv;
    logic [3:0]  sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [11:0] rq,
                              input logic fr, input logic sr,
                              input logic [11:0] pend,
                              input logic fv, input logic [3:0] fc,
                              input logic sv, input logic [3:0] sc);
    vec_t v;
    v.rst = rst; v.req = rq; v.fr = fr; v.sr = sr;
    v.pend = pend; v.fv = fv; v.fc = fc; v.sv = sv; v.sc = sc;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [11:0] rq,
                       input logic fr, input logic sr);
    @(negedge clk);
    reset        = rst;
    req          = rq;
    first_ready  = fr;
    second_ready = sr;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " pending"},      pending,              v.pend);
    check({tag, " first_valid"},  {11'd0, first_valid}, {11'd0, v.fv});
    check({tag, " first_code"},   {8'd0, first_code},   {8'd0, v.fc});
    check({tag, " second_valid"}, {11'd0, second_valid},{11'd0, v.sv});
    check({tag, " second_code"},  {8'd0, second_code},  {8'd0, v.sc});
  endtask

  // ---------------- main test ----------------
  initial begin
    reset = 1'b1; req = '0; first_ready = 1'b0; second_ready = 1'b0;

    //                 rst req     fr sr  pend    fv fc  sv sc
    // reset held with all requests asserted, then idle
    vecs.push_back(mk(1, 12'hFFF, 0, 0, 12'h000, 0, 0,  0, 0));
    vecs.push_back(mk(1, 12'hFFF, 0, 0, 12'h000, 0, 0,  0, 0));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0,  0, 0));
    // single request, then grant it
    vecs.push_back(mk(0, 12'h020, 0, 0, 12'h020, 1, 5,  0, 0));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 0,  0, 0));
    // dual order, both granted together
    vecs.push_back(mk(0, 12'h882, 0, 0, 12'h882, 1, 11, 1, 7));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h002, 1, 1,  0, 0));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h000, 0, 0,  0, 0));
    // regrant collision: grant and re-request index 4 in one cycle
    vecs.push_back(mk(0, 12'h010, 0, 0, 12'h010, 1, 4,  0, 0));
    vecs.push_back(mk(0, 12'h010, 1, 0, 12'h010, 1, 4,  0, 0));
    // only second_ready: first stays put, second retires
    vecs.push_back(mk(0, 12'h0C0, 0, 0, 12'h0D0, 1, 7,  1, 6));
    vecs.push_back(mk(0, 12'h000, 0, 1, 12'h090, 1, 7,  1, 4));
    // higher req arrives while second is granted: codes move without a
    // first handshake
    vecs.push_back(mk(0, 12'h800, 0, 1, 12'h880, 1, 11, 1, 7));
    // both granted, upper nibble requested: pending becomes F00
    vecs.push_back(mk(0, 12'hF00, 1, 1, 12'hF00, 1, 11, 1, 10));
    // reset mid-drain with both readys high
    vecs.push_back(mk(1, 12'h000, 1, 1, 12'h000, 0, 0,  0, 0));
    // merge of a repeated request on a pending index
    vecs.push_back(mk(0, 12'h001, 0, 0, 12'h001, 1, 0,  0, 0));
    vecs.push_back(mk(0, 12'h001, 0, 0, 12'h001, 1, 0,  0, 0));
    // ready on an invalid second port retires nothing extra
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h000, 0, 0,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].fr, vecs[i].sr);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // ---------------- full drain sequence ----------------
    for (int k = 11; k >= 1; k -= 2) begin
      exp_q.push_back({4'(k), 4'(k - 1)});
    end

    drive(0, 12'hFFF, 0, 0);
    @(posedge clk);
    #1;
    check("drain load pending", pending, 12'hFFF);

    begin
      int grants = 0;
      int cycles = 0;
      logic [7:0] exp_pair;
      drive(0, 12'h000, 1, 1);
      while (pending != 12'h000 && cycles < 20) begin
        // outputs are stable here; the next rising edge completes both
        // handshakes
        if (first_valid && second_valid) begin
          if (exp_q.size() == 0) begin
            check("drain extra grant", {8'd0, first_code, second_code}, 12'h000);
          end else begin
            exp_pair = exp_q.pop_front();
            check($sformatf("drain pair%0d", grants),
                  {4'd0, first_code, second_code}, {4'd0, exp_pair});
          end
          grants++;
        end else begin
          check("drain both valid", {10'd0, first_valid, second_valid}, 12'h003);
        end
        @(posedge clk);
        #1;
        cycles++;
      end
      check("drain cycles", 12'(cycles), 12'd6);
      check("drain grant count", 12'(grants), 12'd6);
      check("drain queue empty", 12'(exp_q.size()), 12'd0);
      check("drain pending", pending, 12'h000);
      check("drain valids", {10'd0, first_valid, second_valid}, 12'h000);
    end

    // ---------------- reset mid-drain from F00 ----------------
    drive(0, 12'hF00, 0, 0);
    @(posedge clk);
    #1;
    check("f00 pending", pending, 12'hF00);
    check("f00 codes", {4'd0, first_code, second_code}, 12'h0BA);
    drive(1, 12'h000, 1, 1);
    @(posedge clk);
    #1;
    check("rst pending", pending, 12'h000);
    check("rst valids", {10'd0, first_valid, second_valid}, 12'h000);
    check("rst codes", {4'd0, first_code, second_code}, 12'h000);

    drive(0, 12'h000, 0, 0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
